// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM encoding, default hold limit
// and the request-rotation helper used by the priority encoder.
package rr_arbiter_4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } arb_state_t;

  localparam int HOLD_MAX_DEFAULT = 16;

  // Rotate right by ptr so bit 0 of the result is requester ptr.
  function automatic logic [3:0] rot_req4(input logic [3:0] req, input logic [1:0] ptr);
    logic [7:0] w_dbl;
    w_dbl = {req, req} >> ptr;
    return w_dbl[3:0];
  endfunction

endpackage

// File: rtl/rr_arbiter_4_prio_enc4.sv
// Combinational 4-to-2 priority encoder starting at requester ptr (bit 0 of rotated vector first).
// Zero latency, no flow control; o_vld low when no request is pending.
module prio_enc4
  import rr_arbiter_4_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_idx,
  output logic       o_vld
);

  logic [3:0] w_rot;
  logic [1:0] w_pos;

  always_comb begin
    w_rot = rot_req4(i_req, i_ptr);
    w_pos = 2'd0;
    if (w_rot[0])      w_pos = 2'd0;
    else if (w_rot[1]) w_pos = 2'd1;
    else if (w_rot[2]) w_pos = 2'd2;
    else if (w_rot[3]) w_pos = 2'd3;
    o_vld = |w_rot;
    // Two-bit add wraps naturally, undoing the rotation.
    o_idx = w_pos + i_ptr;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with hold-time limit and one-cycle release turnaround.
// Grant registered one cycle after req is seen; owner holds until done, req drop or HOLD_MAX cycles.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  arb_state_t r_state, w_state_nxt;
  logic [3:0] r_grant, w_grant_nxt;
  logic [1:0] r_grant_id, w_id_nxt;
  logic       r_grant_valid, w_valid_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;

  logic [1:0] w_win_id;
  logic       w_win_vld;

  prio_enc4 u_prio_enc4 (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_idx (w_win_id),
    .o_vld (w_win_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= 4'b0000;
      r_grant_id    <= 2'd0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_ptr         <= 2'd0;
      r_cnt         <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_id    <= w_id_nxt;
      r_grant_valid <= w_valid_nxt;
      r_timeout     <= w_timeout_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_id_nxt      = r_grant_id;
    w_valid_nxt   = r_grant_valid;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;

    case (r_state)
      ST_IDLE, ST_RELEASE: begin
        if (w_win_vld) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = 4'b0001 << w_win_id;
          w_id_nxt    = w_win_id;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 4'b0000;
          w_valid_nxt = 1'b0;
        end
      end
      ST_GRANT: begin
        // Voluntary release is checked first so done beats a coincident timeout.
        if (done || !req[r_grant_id]) begin
          w_state_nxt = ST_RELEASE;
          w_grant_nxt = 4'b0000;
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = r_grant_id + 2'd1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = ST_RELEASE;
          w_grant_nxt   = 4'b0000;
          w_valid_nxt   = 1'b0;
          w_timeout_nxt = 1'b1;
          w_ptr_nxt     = r_grant_id + 2'd1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 4'b0000;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 built with HOLD_MAX=4; checks sampled 1 time unit after each rising edge.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int n_pass = 0;
  int n_tot  = 0;

  rr_arbiter_4 #(.HOLD_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_tot++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Compares grant/valid/timeout; grant_id only when a grant is expected.
  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic v, input logic t);
    chk({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
    chk({tag, ".valid"}, {7'b0, grant_valid}, {7'b0, v});
    chk({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
    if (v) chk({tag, ".id"}, {6'b0, grant_id}, {6'b0, id});
  endtask

  initial begin
    logic [1:0] fair_ids [5];
    fair_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held with all requests active.
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    #2;
    expect_out("rst0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester 2.
    rst_n = 1'b1;
    req   = 4'b0100;
    tick();
    expect_out("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("single_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    expect_out("single_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("reqdrop_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("reqdrop_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Pointer is now 3: all requests grant id 3, then async reset mid-grant.
    req = 4'b1111;
    tick();
    expect_out("ptr3_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_out("midrst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    expect_out("postrst_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("postrst_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset again so fairness starts at ptr 0.
    done  = 1'b0;
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    expect_out("rst_again", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Fairness: done one cycle after each grant.
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      expect_out($sformatf("fair_grant%0d", k), 4'b0001 << fair_ids[k], fair_ids[k], 1'b1, 1'b0);
      done = 1'b1;
      tick();
      expect_out($sformatf("fair_gap%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;
      if (k < 4) tick();
    end
    req = 4'b0000;
    tick();
    expect_out("fair_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Timeout: ptr is 1, only requester 1, no done.
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out($sformatf("hold%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    expect_out("timeout_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    req = 4'b1111;
    tick();
    expect_out("timeout_ptr2", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Collision: done on the same cycle the counter hits HOLD_MAX-1.
    tick();
    tick();
    tick();
    expect_out("coll_last", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("coll_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("done_ignored_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    req  = 4'b0001;
    tick();
    expect_out("wrap_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
